// File: rtl/data_mem_sb.sv
// data_mem_sb: 2**ADDR_W x DATA_W data memory with a FIFO store buffer.
// Stores are posted to the buffer and retire on idle/read cycles.
// Loads forward the youngest buffered store, or fall back to the array.
// Read data is combinational in the same cycle.
// Ports: clk, rst_n (async low), CEN/WEN/OEN (active-low controls),
// A (word address), Data2Mem (store data), ReadDataMem (load data),
// sb_count/sb_full (buffer occupancy), rd_cnt/wr_cnt (cycle counters).
module data_mem_sb #(
  parameter  int ADDR_W   = 7,
  parameter  int DATA_W   = 32,
  parameter  int SB_DEPTH = 4,
  localparam int PW       = $clog2(SB_DEPTH),
  localparam int CW       = PW + 1,
  localparam int WORDS    = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] Data2Mem,
  output logic [DATA_W-1:0] ReadDataMem,
  output logic [CW-1:0]     sb_count,
  output logic              sb_full,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt
);

  logic [DATA_W-1:0] mem_q     [WORDS];
  logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
  logic [DATA_W-1:0] sb_data_q [SB_DEPTH];

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     cnt_q,  cnt_d;
  logic [31:0]       rd_cnt_q, rd_cnt_d;
  logic [31:0]       wr_cnt_q, wr_cnt_d;

  logic              is_st;
  logic              is_rd;
  logic              sb_empty;
  logic              sb_is_full;
  logic              drain;

  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PW-1:0]     fwd_idx;
  logic [DATA_W-1:0] rd_data;

  // Cycle classification
  always_comb begin
    is_st = ~CEN & ~WEN;
    is_rd = ~CEN & WEN & ~OEN;
  end

  // Occupancy and drain decision
  always_comb begin
    sb_empty   = (cnt_q == '0);
    sb_is_full = (cnt_q == CW'(SB_DEPTH));
    // A full buffer must make room for a new store on the same edge.
    drain      = ~sb_empty & (~is_st | sb_is_full);
  end

  // Pointer and counter next-state
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;

    if (drain) begin
      head_d = head_q + PW'(1);
    end

    if (is_st) begin
      tail_d   = tail_q + PW'(1);
      wr_cnt_d = wr_cnt_q + 32'd1;
    end

    unique case ({is_st, drain})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (is_rd) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end
  end

  // Head entry being retired to the array
  always_comb begin
    mem_wa = sb_addr_q[head_q];
    mem_wd = sb_data_q[head_q];
  end

  // Forwarding: scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = head_q;
    for (int k = 0; k < SB_DEPTH; k++) begin
      fwd_idx = head_q + PW'(k);
      if ((CW'(k) < cnt_q) && (sb_addr_q[fwd_idx] == A)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data_q[fwd_idx];
      end
    end
  end

  // Read mux; zero on non-read cycles and while in reset
  always_comb begin
    rd_data = '0;
    if (rst_n && is_rd) begin
      rd_data = fwd_hit ? fwd_data : mem_q[A];
    end
  end

  // Buffer control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Buffer payload; on a full-buffer store tail equals head, and the
  // old head value is still read for the drain on this same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr_q[i] <= '0;
        sb_data_q[i] <= '0;
      end
    end else if (is_st) begin
      sb_addr_q[tail_q] <= A;
      sb_data_q[tail_q] <= Data2Mem;
    end
  end

  // Array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (drain) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign ReadDataMem = rd_data;
  assign sb_count    = cnt_q;
  assign sb_full     = sb_is_full;
  assign rd_cnt      = rd_cnt_q;
  assign wr_cnt      = wr_cnt_q;

endmodule

// File: tb/tb_data_mem_sb.sv
// tb_data_mem_sb: scoreboard bench for data_mem_sb.
// Directed scenarios plus randomized traffic against a queue-based model.
module tb_data_mem_sb;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 32;
  localparam int SB_DEPTH = 4;
  localparam int CW       = $clog2(SB_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              CEN = 1'b1;
  logic              WEN = 1'b1;
  logic              OEN = 1'b1;
  logic [ADDR_W-1:0] A = '0;
  logic [DATA_W-1:0] Data2Mem = '0;
  logic [DATA_W-1:0] ReadDataMem;
  logic [CW-1:0]     sb_count;
  logic              sb_full;
  logic [31:0]       rd_cnt;
  logic [31:0]       wr_cnt;

  data_mem_sb #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .SB_DEPTH(SB_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .CEN        (CEN),
    .WEN        (WEN),
    .OEN        (OEN),
    .A          (A),
    .Data2Mem   (Data2Mem),
    .ReadDataMem(ReadDataMem),
    .sb_count   (sb_count),
    .sb_full    (sb_full),
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] cnt;
    logic        full;
    logic [31:0] rdc;
    logic [31:0] wrc;
  } exp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } st_t;

  exp_t        expq[$];
  st_t         m_sb[$];
  logic [31:0] m_mem [1 << ADDR_W];
  logic [31:0] m_rdc;
  logic [31:0] m_wrc;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string n, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t",
               n, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    foreach (m_mem[i]) m_mem[i] = '0;
    m_sb.delete();
    m_rdc = '0;
    m_wrc = '0;
  endfunction

  // Youngest buffered store to this address, else the array word.
  function automatic logic [31:0] model_read(logic [ADDR_W-1:0] a);
    for (int i = m_sb.size() - 1; i >= 0; i--) begin
      if (m_sb[i].a == a) return m_sb[i].d;
    end
    return m_mem[a];
  endfunction

  // kind: 0 idle(CEN=1), 4 idle(CEN=0,WEN=1,OEN=1),
  //       1 read, 2 store, 3 store with OEN low
  task automatic cyc(input int kind, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d);
    exp_t e;
    st_t  s;
    logic rd;
    logic st;
    @(negedge clk);
    case (kind)
      1: begin CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; end
      2: begin CEN = 1'b0; WEN = 1'b0; OEN = 1'b1; end
      3: begin CEN = 1'b0; WEN = 1'b0; OEN = 1'b0; end
      4: begin CEN = 1'b0; WEN = 1'b1; OEN = 1'b1; end
      default: begin
        CEN = 1'b1;
        WEN = 1'($urandom_range(0, 1));
        OEN = 1'($urandom_range(0, 1));
      end
    endcase
    A        = a;
    Data2Mem = d;
    rd = (kind == 1);
    st = (kind == 2) || (kind == 3);

    e.rdata = rd ? model_read(a) : 32'd0;
    e.cnt   = 32'(m_sb.size());
    e.full  = (m_sb.size() == SB_DEPTH);
    e.rdc   = m_rdc;
    e.wrc   = m_wrc;
    expq.push_back(e);

    if (st) begin
      if (m_sb.size() == SB_DEPTH) begin
        s = m_sb.pop_front();
        m_mem[s.a] = s.d;
      end
      s.a = a;
      s.d = d;
      m_sb.push_back(s);
      m_wrc = m_wrc + 32'd1;
    end else if (m_sb.size() > 0) begin
      s = m_sb.pop_front();
      m_mem[s.a] = s.d;
    end
    if (rd) m_rdc = m_rdc + 32'd1;
  endtask

  // Pulse reset between edges and check it takes effect at once.
  task automatic reset_pulse();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_sb_count", 32'(sb_count), 32'd0);
    chk("rst_sb_full", 32'(sb_full), 32'd0);
    chk("rst_rd_cnt", rd_cnt, 32'd0);
    chk("rst_wr_cnt", wr_cnt, 32'd0);
    chk("rst_rdata", ReadDataMem, 32'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: samples one time unit before each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("ReadDataMem", ReadDataMem, e.rdata);
        chk("sb_count", 32'(sb_count), e.cnt);
        chk("sb_full", 32'(sb_full), 32'(e.full));
        chk("rd_cnt", rd_cnt, e.rdc);
        chk("wr_cnt", wr_cnt, e.wrc);
      end
    end
  end

  initial begin
    int r;
    int k;
    logic [ADDR_W-1:0] ra;
    model_reset();
    #1;
    chk("init_sb_count", 32'(sb_count), 32'd0);
    chk("init_rd_cnt", rd_cnt, 32'd0);
    chk("init_wr_cnt", wr_cnt, 32'd0);
    chk("init_rdata", ReadDataMem, 32'd0);
    #11;
    rst_n = 1'b1;

    cyc(1, 7'd5, '0);
    cyc(0, 7'd0, '0);

    cyc(2, 7'd3, 32'hDEADBEEF);
    cyc(1, 7'd3, '0);
    cyc(0, 7'd0, '0);
    cyc(1, 7'd3, '0);

    cyc(2, 7'd7, 32'h11);
    cyc(2, 7'd7, 32'h22);
    cyc(1, 7'd7, '0);
    cyc(0, 7'd0, '0);
    cyc(4, 7'd0, '0);
    cyc(1, 7'd7, '0);

    reset_pulse();
    for (int i = 0; i < 6; i++) begin
      cyc(2, 7'(i), 32'h100 + 32'(i));
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1, 7'(i), '0);
    end
    cyc(0, 7'd0, '0);

    cyc(2, 7'd9, 32'hAA);
    cyc(3, 7'd9, 32'hBB);
    cyc(1, 7'd9, '0);

    cyc(2, 7'd20, 32'h1);
    cyc(2, 7'd21, 32'h2);
    cyc(2, 7'd22, 32'h3);
    reset_pulse();
    cyc(1, 7'd20, '0);
    cyc(1, 7'd21, '0);
    cyc(1, 7'd22, '0);

    for (int n = 0; n < 1500; n++) begin
      r  = int'($urandom_range(0, 99));
      ra = (r < 80) ? 7'($urandom_range(0, 7))
                    : 7'($urandom_range(0, 127));
      k  = (r < 38) ? 2 :
           (r < 68) ? 1 :
           (r < 82) ? 0 :
           (r < 92) ? 4 :
           (r < 99) ? 3 : 5;
      if (k == 5) reset_pulse();
      else cyc(k, ra, $urandom);
    end
    cyc(0, 7'd0, '0);

    for (int i = 0; i < 10 && expq.size() > 0; i++) begin
      @(posedge clk);
    end
    if (expq.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0",
               expq.size());
    end
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
